// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, fetch write enables,
// branch-flush bubbles and a saturating stall-cycle counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic [DATA_W-1:0] id_rdata1_i,
   input  logic [DATA_W-1:0] id_rdata2_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [DATA_W-1:0] id_pc4_i,
   input  logic [9:0]        id_ctrl_i,
   input  logic              flush_i,
   input  logic              hold_i,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [DATA_W-1:0] ex_rdata1_o,
   output logic [DATA_W-1:0] ex_rdata2_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [DATA_W-1:0] ex_pc4_o,
   output logic [9:0]        ex_ctrl_o,
   output logic              ex_valid_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   // ctrl layout: {RegWrite, MemToReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[2:0]}
   localparam int MEM_READ_BIT = 7;

   logic rs_hit;
   logic rt_hit;
   logic hz;
   logic fetch_en;

   always_comb begin
      rs_hit = id_uses_rs_i && (id_rs_i == ex_rt_o);
      rt_hit = id_uses_rt_i && (id_rt_i == ex_rt_o);
      hz     = ex_valid_o && ex_ctrl_o[MEM_READ_BIT] && (ex_rt_o != '0) && (rs_hit || rt_hit);
      // a taken branch overrides the stall so the PC can pick up the target
      fetch_en = !(hz && !flush_i) && !hold_i;
   end

   assign pc_write_o   = fetch_en;
   assign ifid_write_o = fetch_en;

   // Operand/address fields carry no meaning in a bubble, so they load on every
   // non-held edge; only ctrl and valid decide whether the slot is live.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_rs_o     <= '0;
         ex_rt_o     <= '0;
         ex_rd_o     <= '0;
         ex_rdata1_o <= '0;
         ex_rdata2_o <= '0;
         ex_imm_o    <= '0;
         ex_pc4_o    <= '0;
      end else if (flush_i || !hold_i) begin
         ex_rs_o     <= id_rs_i;
         ex_rt_o     <= id_rt_i;
         ex_rd_o     <= id_rd_i;
         ex_rdata1_o <= id_rdata1_i;
         ex_rdata2_o <= id_rdata2_i;
         ex_imm_o    <= id_imm_i;
         ex_pc4_o    <= id_pc4_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_ctrl_o   <= '0;
         ex_valid_o  <= 1'b0;
         stall_cnt_o <= '0;
      end else if (flush_i) begin
         ex_ctrl_o  <= '0;
         ex_valid_o <= 1'b0;
      end else if (hold_i) begin
         ex_ctrl_o  <= ex_ctrl_o;
         ex_valid_o <= ex_valid_o;
      end else if (hz) begin
         ex_ctrl_o  <= '0;
         ex_valid_o <= 1'b0;
         if (stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end
      end else begin
         ex_ctrl_o  <= id_ctrl_i;
         ex_valid_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of per-cycle vectors checked through a scoreboard
// queue, plus a counter-saturation sequence on a narrow-counter instance.
module tb_id_ex_stage;

   localparam logic [9:0] ADD = 10'h20A;  // RegWrite, RegDst, ALUOp=010
   localparam logic [9:0] LW  = 10'h390;  // RegWrite, MemToReg, MemRead, ALUSrc

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
   logic [9:0]  id_ctrl;
   logic        flush, hold;

   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
   logic [9:0]  ex_ctrl;
   logic        ex_valid, pc_write, ifid_write;
   logic [15:0] stall_cnt;

   logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
   logic [31:0] s_ex_rdata1, s_ex_rdata2, s_ex_imm, s_ex_pc4;
   logic [9:0]  s_ex_ctrl;
   logic        s_ex_valid, s_pc_write, s_ifid_write;
   logic [1:0]  s_stall_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk_i(clk), .rst_i(rst),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
      .id_rdata1_i(id_rdata1), .id_rdata2_i(id_rdata2),
      .id_imm_i(id_imm), .id_pc4_i(id_pc4), .id_ctrl_i(id_ctrl),
      .flush_i(flush), .hold_i(hold),
      .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
      .ex_rdata1_o(ex_rdata1), .ex_rdata2_o(ex_rdata2),
      .ex_imm_o(ex_imm), .ex_pc4_o(ex_pc4), .ex_ctrl_o(ex_ctrl),
      .ex_valid_o(ex_valid), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
      .stall_cnt_o(stall_cnt)
   );

   id_ex_stage #(.CNT_W(2)) dut_sat (
      .clk_i(clk), .rst_i(rst),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
      .id_rdata1_i(id_rdata1), .id_rdata2_i(id_rdata2),
      .id_imm_i(id_imm), .id_pc4_i(id_pc4), .id_ctrl_i(id_ctrl),
      .flush_i(flush), .hold_i(hold),
      .ex_rs_o(s_ex_rs), .ex_rt_o(s_ex_rt), .ex_rd_o(s_ex_rd),
      .ex_rdata1_o(s_ex_rdata1), .ex_rdata2_o(s_ex_rdata2),
      .ex_imm_o(s_ex_imm), .ex_pc4_o(s_ex_pc4), .ex_ctrl_o(s_ex_ctrl),
      .ex_valid_o(s_ex_valid), .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
      .stall_cnt_o(s_stall_cnt)
   );

   typedef struct {
      logic        rst, flush, hold;
      logic [4:0]  rs, rt, rd;
      logic        urs, urt;
      logic [31:0] d;
      logic [9:0]  ctrl;
      logic        we;
      logic        ev;
      logic [9:0]  ectrl;
      logic [4:0]  ers, ert, erd;
      logic [31:0] ed;
      logic [15:0] ecnt;
      logic        chk_data;
   } vec_t;

   typedef struct {
      int          idx;
      logic        ev;
      logic [9:0]  ectrl;
      logic [4:0]  ers, ert, erd;
      logic [31:0] ed;
      logic [15:0] ecnt;
      logic        chk_data;
   } exp_t;

   vec_t vt[21];
   exp_t sb[$];

   function automatic vec_t mk(
      logic r, logic f, logic h, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
      logic urs, logic urt, logic [31:0] d, logic [9:0] c, logic we,
      logic ev, logic [9:0] ec, logic [4:0] ers, logic [4:0] ert, logic [4:0] erd,
      logic [31:0] ed, logic [15:0] ecnt, logic chk);
      vec_t v;
      v.rst = r; v.flush = f; v.hold = h; v.rs = rs; v.rt = rt; v.rd = rd;
      v.urs = urs; v.urt = urt; v.d = d; v.ctrl = c; v.we = we;
      v.ev = ev; v.ectrl = ec; v.ers = ers; v.ert = ert; v.erd = erd;
      v.ed = ed; v.ecnt = ecnt; v.chk_data = chk;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // operands 2/imm/pc4 are derived from d so one expected value covers all four
   task automatic drive(logic r, logic f, logic h, logic [4:0] rs, logic [4:0] rt,
                        logic [4:0] rd, logic urs, logic urt, logic [31:0] d, logic [9:0] c);
      rst = r; flush = f; hold = h;
      id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = urs; id_uses_rt = urt;
      id_rdata1 = d; id_rdata2 = d * 3; id_imm = d << 1; id_pc4 = d << 2;
      id_ctrl = c;
   endtask

   task automatic apply(int i);
      exp_t e;
      exp_t g;
      drive(vt[i].rst, vt[i].flush, vt[i].hold, vt[i].rs, vt[i].rt, vt[i].rd,
            vt[i].urs, vt[i].urt, vt[i].d, vt[i].ctrl);
      #1;
      chk($sformatf("row%0d pc_write", i), pc_write, vt[i].we);
      chk($sformatf("row%0d ifid_write", i), ifid_write, vt[i].we);
      e.idx = i; e.ev = vt[i].ev; e.ectrl = vt[i].ectrl; e.ers = vt[i].ers;
      e.ert = vt[i].ert; e.erd = vt[i].erd; e.ed = vt[i].ed; e.ecnt = vt[i].ecnt;
      e.chk_data = vt[i].chk_data;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk($sformatf("row%0d ex_valid", g.idx), ex_valid, g.ev);
      chk($sformatf("row%0d ex_ctrl", g.idx), ex_ctrl, g.ectrl);
      chk($sformatf("row%0d stall_cnt", g.idx), stall_cnt, g.ecnt);
      if (g.chk_data) begin
         chk($sformatf("row%0d ex_rs", g.idx), ex_rs, g.ers);
         chk($sformatf("row%0d ex_rt", g.idx), ex_rt, g.ert);
         chk($sformatf("row%0d ex_rd", g.idx), ex_rd, g.erd);
         chk($sformatf("row%0d ex_rdata1", g.idx), ex_rdata1, g.ed);
         chk($sformatf("row%0d ex_rdata2", g.idx), ex_rdata2, g.ed * 3);
         chk($sformatf("row%0d ex_imm", g.idx), ex_imm, g.ed << 1);
         chk($sformatf("row%0d ex_pc4", g.idx), ex_pc4, g.ed << 2);
      end
      @(negedge clk);
   endtask

   initial begin
      //        rst fl ho rs rt rd urs urt d      ctrl we | ev ectrl ers ert erd ed     cnt chk
      vt[0]  = mk(0, 0, 0, 1, 2, 3, 1, 1, 'h11, ADD, 1, 1, ADD, 1, 2, 3, 'h11, 0, 1);
      vt[1]  = mk(0, 0, 0, 4, 5, 0, 1, 0, 'h22, LW,  1, 1, LW,  4, 5, 0, 'h22, 0, 1);
      vt[2]  = mk(0, 0, 0, 5, 6, 7, 1, 1, 'h33, ADD, 0, 0, 0,   0, 0, 0, 0,    1, 0);
      vt[3]  = mk(0, 0, 0, 5, 6, 7, 1, 1, 'h33, ADD, 1, 1, ADD, 5, 6, 7, 'h33, 1, 1);
      vt[4]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 'h44, LW,  1, 1, LW,  1, 0, 0, 'h44, 1, 1);
      vt[5]  = mk(0, 0, 0, 0, 0, 8, 1, 1, 'h55, ADD, 1, 1, ADD, 0, 0, 8, 'h55, 1, 1);
      vt[6]  = mk(0, 0, 0, 2, 5, 0, 1, 0, 'h66, LW,  1, 1, LW,  2, 5, 0, 'h66, 1, 1);
      vt[7]  = mk(0, 0, 0, 1, 5, 9, 1, 0, 'h77, ADD, 1, 1, ADD, 1, 5, 9, 'h77, 1, 1);
      vt[8]  = mk(0, 0, 0, 3, 5, 0, 1, 0, 'h88, LW,  1, 1, LW,  3, 5, 0, 'h88, 1, 1);
      vt[9]  = mk(0, 1, 0, 1, 5, 10, 1, 1, 'h99, ADD, 1, 0, 0,  0, 0, 0, 0,    1, 0);
      vt[10] = mk(0, 0, 0, 0, 6, 0, 1, 0, 'hAA, LW,  1, 1, LW,  0, 6, 0, 'hAA, 1, 1);
      vt[11] = mk(0, 0, 0, 6, 7, 0, 1, 0, 'hBB, LW,  0, 0, 0,   0, 0, 0, 0,    2, 0);
      vt[12] = mk(0, 0, 0, 6, 7, 0, 1, 0, 'hBB, LW,  1, 1, LW,  6, 7, 0, 'hBB, 2, 1);
      vt[13] = mk(0, 0, 0, 7, 7, 12, 1, 1, 'hCC, ADD, 0, 0, 0,  0, 0, 0, 0,    3, 0);
      vt[14] = mk(0, 0, 0, 7, 7, 12, 1, 1, 'hCC, ADD, 1, 1, ADD, 7, 7, 12, 'hCC, 3, 1);
      vt[15] = mk(0, 0, 1, 1, 2, 3, 1, 1, 'hDD, ADD, 0, 1, ADD, 7, 7, 12, 'hCC, 3, 1);
      vt[16] = mk(0, 0, 1, 1, 2, 3, 1, 1, 'hDD, ADD, 0, 1, ADD, 7, 7, 12, 'hCC, 3, 1);
      vt[17] = mk(0, 0, 1, 1, 2, 3, 1, 1, 'hDD, ADD, 0, 1, ADD, 7, 7, 12, 'hCC, 3, 1);
      vt[18] = mk(0, 0, 0, 1, 2, 3, 1, 1, 'hDD, ADD, 1, 1, ADD, 1, 2, 3, 'hDD, 3, 1);
      vt[19] = mk(1, 0, 0, 5, 5, 5, 1, 1, 'hEE, LW,  1, 0, 0,   0, 0, 0, 0,    0, 1);
      vt[20] = mk(0, 0, 0, 1, 2, 3, 1, 1, 'h12, ADD, 1, 1, ADD, 1, 2, 3, 'h12, 0, 1);

      drive(1, 0, 0, 9, 9, 9, 1, 1, 'h5A5A, LW);
      repeat (2) @(posedge clk);
      #1;
      chk("reset ex_valid", ex_valid, 0);
      chk("reset ex_ctrl", ex_ctrl, 0);
      chk("reset ex_rs", ex_rs, 0);
      chk("reset ex_rt", ex_rt, 0);
      chk("reset ex_rd", ex_rd, 0);
      chk("reset ex_rdata1", ex_rdata1, 0);
      chk("reset ex_pc4", ex_pc4, 0);
      chk("reset stall_cnt", stall_cnt, 0);
      chk("reset pc_write", pc_write, 1);
      chk("reset ifid_write", ifid_write, 1);
      @(negedge clk);

      for (int i = 0; i < 21; i++) apply(i);

      // saturation: "lw $5,0($5)" held in ID stalls on every other edge
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 5, 5, 0, 1, 0, 'h100, LW);
      repeat (4) @(posedge clk);
      #1;
      chk("sat cnt16 after 2 hz", stall_cnt, 2);
      chk("sat cnt2 after 2 hz", s_stall_cnt, 2);
      repeat (5) @(posedge clk);
      #1;
      chk("sat pc_write during hz", s_pc_write, 0);
      chk("sat ifid_write during hz", s_ifid_write, 0);
      @(posedge clk);
      #1;
      chk("sat cnt16 after 5 hz", stall_cnt, 5);
      chk("sat cnt2 saturated", s_stall_cnt, 3);
      chk("sat bubble valid", s_ex_valid, 0);
      chk("sat bubble ctrl", s_ex_ctrl, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
